// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, waiting on the
// instruction and data memory ready handshakes, and drives the PC, IR,
// register-file and data-memory strobes plus the PC and writeback selects.
// Also keeps the retired-instruction count and the sticky halt/error status.
module multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       wb_sel,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [2:0] WB_ALU   = 3'b000;
    localparam logic [2:0] WB_MEM   = 3'b001;
    localparam logic [2:0] WB_PC4   = 3'b010;
    localparam logic [2:0] WB_PCIMM = 3'b011;
    localparam logic [2:0] WB_IMM   = 3'b100;

    // A wait times out on its MAX_WAIT-th not-ready cycle, i.e. when the
    // count of earlier not-ready cycles already equals MAX_WAIT-1.
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [6:0]       op_q;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] instret_q;
    logic             illegal_q;
    logic             bus_err_q;

    logic             in_wait;
    logic             wait_ready;
    logic             timeout;
    logic             illegal_set;
    state_t           boundary;

    // Opcodes the datapath can execute (SYSTEM is handled separately).
    function automatic logic is_known(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_R, OP_IALU,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_known = 1'b1;
            default:                           is_known = 1'b0;
        endcase
    endfunction

    assign in_wait    = (state_q == S_FETCH) || (state_q == S_MEM);
    assign wait_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;
    // Ready in the limit cycle wins, so timeout requires ready low.
    assign timeout    = in_wait && !wait_ready && (wait_cnt == WAIT_LIMIT);
    assign boundary   = run ? S_FETCH : S_IDLE;

    // Next-state and strobe/select decode from the current state and op_q.
    always_comb begin
        state_d     = state_q;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        reg_we      = 1'b0;
        dmem_re     = 1'b0;
        dmem_we     = 1'b0;
        pc_sel      = PC_PLUS4;
        wb_sel      = WB_ALU;
        illegal_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                if (opcode == OP_SYSTEM) begin
                    state_d = S_HALT;
                end else if (!is_known(opcode)) begin
                    illegal_set = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken ? PC_IMM : PC_PLUS4;
                        state_d = boundary;
                    end
                    OP_LOAD, OP_STORE:                 state_d = S_MEM;
                    OP_R, OP_IALU, OP_LUI, OP_AUIPC,
                    OP_JAL, OP_JALR:                   state_d = S_WB;
                    default:                           state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (op_q == OP_LOAD) begin
                    dmem_re = !timeout;
                    if (dmem_ready)   state_d = S_WB;
                    else if (timeout) state_d = S_HALT;
                end else begin
                    dmem_we = !timeout;
                    if (dmem_ready) begin
                        pc_we   = 1'b1;
                        state_d = boundary;
                    end else if (timeout) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                state_d = boundary;
                case (op_q)
                    OP_LOAD:  wb_sel = WB_MEM;
                    OP_LUI:   wb_sel = WB_IMM;
                    OP_AUIPC: wb_sel = WB_PCIMM;
                    OP_JAL: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_IMM;
                    end
                    OP_JALR: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_ALU;
                    end
                    default:  wb_sel = WB_ALU;
                endcase
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register and latched opcode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 7'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= opcode;
        end
    end

    // Memory wait counter: restarts on every state change, counts not-ready cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 8'd0;
        end else if (state_d != state_q) begin
            wait_cnt <= 8'd0;
        end else if (in_wait && !wait_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Retired-instruction counter and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (pc_we)       instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (illegal_set) illegal_q <= 1'b1;
            if (timeout)     bus_err_q <= 1'b1;
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Strobe vectors: {pc_we, ir_we, reg_we, dmem_re, dmem_we}
    localparam logic [4:0] NONE  = 5'b00000;
    localparam logic [4:0] IR    = 5'b01000;
    localparam logic [4:0] PC    = 5'b10000;
    localparam logic [4:0] WBS   = 5'b10100;
    localparam logic [4:0] RE    = 5'b00010;
    localparam logic [4:0] WE    = 5'b00001;
    localparam logic [4:0] PCWE  = 5'b10001;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [6:0]  opcode;
    logic        imem_ready;
    logic        dmem_ready;
    logic        branch_taken;
    logic        pc_we, ir_we, reg_we, dmem_re, dmem_we;
    logic [1:0]  pc_sel;
    logic [2:0]  wb_sel;
    logic [2:0]  state;
    logic        halted, illegal, bus_err;
    logic [31:0] instret;

    int tests = 0;
    int fails = 0;

    multicycle_ctrl #(.CNT_W(32), .MAX_WAIT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .opcode       (opcode),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .pc_we        (pc_we),
        .ir_we        (ir_we),
        .reg_we       (reg_we),
        .dmem_re      (dmem_re),
        .dmem_we      (dmem_we),
        .pc_sel       (pc_sel),
        .wb_sel       (wb_sel),
        .state        (state),
        .halted       (halted),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare state, strobes and selects of the current cycle in one go.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [4:0] stb,
                       input logic [1:0] ps, input logic [2:0] ws);
        logic [12:0] obs;
        logic [12:0] exp;
        obs = {state, pc_we, ir_we, reg_we, dmem_re, dmem_we, pc_sel, wb_sel};
        exp = {st, stb, ps, ws};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed st/stb/pc/wb=%b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Pulse reset and return to IDLE just after a rising edge.
    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; opcode = 7'd0;
        imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        #12;
        cyc("reset_outputs", 3'd0, NONE, 2'b00, 3'b000);
        chk("reset_instret", instret, 32'd0);
        chk("reset_flags", 32'({halted, illegal, bus_err}), 32'd0);

        // ADDI with all readies high
        tick();
        reset = 1'b1; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = OP_IALU;
        settle(); cyc("addi_idle", 3'd0, NONE, 2'b00, 3'b000);
        tick(); settle(); cyc("addi_fetch", 3'd1, IR, 2'b00, 3'b000);
        tick(); settle(); cyc("addi_decode", 3'd2, NONE, 2'b00, 3'b000);
        tick(); settle(); cyc("addi_exec", 3'd3, NONE, 2'b00, 3'b000);
        tick(); settle(); cyc("addi_wb", 3'd5, WBS, 2'b00, 3'b000);
        tick();

        // LOAD with dmem_ready low for 3 MEM cycles
        opcode = OP_LOAD; dmem_ready = 1'b0;
        settle(); chk("instret_after_addi", instret, 32'd1);
        cyc("load_fetch", 3'd1, IR, 2'b00, 3'b000);
        tick(); settle(); cyc("load_decode", 3'd2, NONE, 2'b00, 3'b000);
        tick(); settle(); cyc("load_exec", 3'd3, NONE, 2'b00, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick(); settle(); cyc("load_mem_wait", 3'd4, RE, 2'b00, 3'b000);
        end
        tick(); dmem_ready = 1'b1;
        settle(); cyc("load_mem_ready", 3'd4, RE, 2'b00, 3'b000);
        tick(); settle(); cyc("load_wb", 3'd5, WBS, 2'b00, 3'b001);
        tick();

        // BEQ taken
        opcode = OP_BRANCH; branch_taken = 1'b1;
        settle(); chk("instret_after_load", instret, 32'd2);
        cyc("beq_fetch", 3'd1, IR, 2'b00, 3'b000);
        tick(); settle(); cyc("beq_decode", 3'd2, NONE, 2'b00, 3'b000);
        tick(); settle(); cyc("beq_exec", 3'd3, PC, 2'b01, 3'b000);
        tick();

        // BNE not taken
        branch_taken = 1'b0;
        settle(); chk("instret_after_beq", instret, 32'd3);
        cyc("bne_fetch", 3'd1, IR, 2'b00, 3'b000);
        tick(); tick(); settle(); cyc("bne_exec", 3'd3, PC, 2'b00, 3'b000);
        tick();

        // JALR
        opcode = OP_JALR;
        settle(); chk("instret_after_bne", instret, 32'd4);
        tick(); tick(); settle(); cyc("jalr_exec", 3'd3, NONE, 2'b00, 3'b000);
        tick(); settle(); cyc("jalr_wb", 3'd5, WBS, 2'b10, 3'b010);
        tick();

        // ECALL halts without retiring
        opcode = OP_SYSTEM;
        settle(); cyc("ecall_fetch", 3'd1, IR, 2'b00, 3'b000);
        tick(); settle(); cyc("ecall_decode", 3'd2, NONE, 2'b00, 3'b000);
        tick(); settle(); cyc("ecall_halt", 3'd6, NONE, 2'b00, 3'b000);
        chk("ecall_halted", 32'(halted), 32'd1);
        tick(); tick(); settle();
        cyc("halt_sticks", 3'd6, NONE, 2'b00, 3'b000);
        chk("ecall_instret", instret, 32'd5);
        chk("ecall_no_err", 32'({illegal, bus_err}), 32'd0);

        // Asynchronous reset clears state and counter without a clock edge
        reset = 1'b0;
        settle();
        cyc("async_reset_state", 3'd0, NONE, 2'b00, 3'b000);
        chk("async_reset_instret", instret, 32'd0);
        chk("async_reset_halted", 32'(halted), 32'd0);

        // imem_ready low for 15 cycles -> bus error
        tick(); reset = 1'b1; imem_ready = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) begin
            settle(); cyc("fetch_wait", 3'd1, NONE, 2'b00, 3'b000);
            tick();
        end
        settle();
        cyc("timeout_halt", 3'd6, NONE, 2'b00, 3'b000);
        chk("timeout_bus_err", 32'(bus_err), 32'd1);
        chk("timeout_halted", 32'(halted), 32'd1);

        // Ready on the 15th wait cycle wins; opcode 0 is illegal
        do_reset();
        chk("bus_err_cleared", 32'(bus_err), 32'd0);
        opcode = 7'd0;
        tick();
        for (int i = 0; i < 14; i++) tick();
        imem_ready = 1'b1;
        settle(); cyc("fetch_ready_15th", 3'd1, IR, 2'b00, 3'b000);
        tick(); settle();
        cyc("no_timeout_decode", 3'd2, NONE, 2'b00, 3'b000);
        chk("no_timeout_bus_err", 32'(bus_err), 32'd0);
        tick(); settle();
        cyc("illegal_halt", 3'd6, NONE, 2'b00, 3'b000);
        chk("illegal_flag", 32'({illegal, bus_err}), 32'b10);
        chk("illegal_instret", instret, 32'd0);

        // run dropped during STORE MEM: store completes, then IDLE
        do_reset();
        opcode = OP_STORE; dmem_ready = 1'b0;
        tick(); tick(); tick(); tick();
        settle(); cyc("store_mem", 3'd4, WE, 2'b00, 3'b000);
        run = 1'b0;
        tick(); dmem_ready = 1'b1;
        settle(); cyc("store_mem_ready", 3'd4, PCWE, 2'b00, 3'b000);
        tick(); settle();
        cyc("store_to_idle", 3'd0, NONE, 2'b00, 3'b000);
        chk("store_instret", instret, 32'd1);
        tick(); settle();
        cyc("idle_holds", 3'd0, NONE, 2'b00, 3'b000);

        // Reset during EXEC of an ADDI
        opcode = OP_IALU; run = 1'b1;
        tick(); tick(); tick(); settle();
        cyc("exec_before_reset", 3'd3, NONE, 2'b00, 3'b000);
        chk("exec_instret", instret, 32'd1);
        reset = 1'b0;
        settle();
        cyc("reset_in_exec", 3'd0, NONE, 2'b00, 3'b000);
        chk("reset_in_exec_instret", instret, 32'd0);
        tick(); settle();
        cyc("reset_held", 3'd0, NONE, 2'b00, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath. It replaces the single-cycle combinational control with a FETCH/DECODE/EXEC/MEM/WB state machine, so instruction and data memories may take several cycles via ready handshakes. It drives the write strobes (PC, IR, register file, data memory) and the existing PC and writeback mux selects. It also keeps a retired-instruction counter and a halt/error status.

Parameters:
CNT_W, 32, width of instret counter
MAX_WAIT, 15, max cycles spent in one memory wait before bus error (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
run  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
opcode  in  7  IR[6:0], valid from DECODE onward
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
branch_taken  in  1  ALU branch compare result, valid in EXEC
pc_we  out  1  PC load strobe
ir_we  out  1  instruction register load strobe
reg_we  out  1  register file write strobe
dmem_re  out  1  data memory read request
dmem_we  out  1  data memory write request
pc_sel  out  2  00 PC+4, 01 PC+imm, 10 ALU (JALR)
wb_sel  out  3  000 ALU, 001 MEM, 010 PC+4, 011 PC+imm, 100 Imm
state  out  3  current state encoding (debug)
halted  out  1  1 in HALT
illegal  out  1  sticky, unknown opcode seen
bus_err  out  1  sticky, memory wait timeout
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (async assert, sync release): state=IDLE, op_q=0, wait_cnt=0, instret=0, illegal=0, bus_err=0. All strobes 0, pc_sel=00, wb_sel=000.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Strobes and selects are combinational from state, op_q and the ready/branch inputs. Only one state transition occurs per cycle.
- IDLE: all strobes 0. Go to FETCH when run=1.
- FETCH: wait for imem_ready. On imem_ready=1, pulse ir_we for that cycle and go to DECODE.
- DECODE: register op_q<=opcode, then dispatch:
  - 1110011 (SYSTEM): go to HALT; does not retire.
  - Unknown opcode: set illegal, go to HALT.
  - All others: go to EXEC.
- EXEC, by op_q:
  - BRANCH 1100011: pc_we=1, pc_sel = branch_taken ? 01 : 00; retire; go to FETCH or IDLE.
  - LOAD 0000011, STORE 0100011: go to MEM.
  - R 0110011, I-ALU 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111: go to WB.
- MEM:
  - LOAD holds dmem_re=1 until dmem_ready, then goes to WB.
  - STORE holds dmem_we=1 until dmem_ready. On the dmem_ready cycle: pc_we=1, pc_sel=00, retire, go to FETCH or IDLE.
- WB (single cycle): reg_we=1, pc_we=1, then retire and go to FETCH or IDLE. Selects by op_q:
  - R, I-ALU: wb_sel=000, pc_sel=00.
  - LOAD: wb_sel=001, pc_sel=00.
  - LUI: wb_sel=100, pc_sel=00.
  - AUIPC: wb_sel=011, pc_sel=00.
  - JAL: wb_sel=010, pc_sel=01.
  - JALR: wb_sel=010, pc_sel=10.
- Instruction boundary: after a retiring cycle, next state is FETCH if run=1, else IDLE. Deasserting run mid-instruction never aborts it.
- Retire: instret += 1 in the same cycle pc_we=1. Wraps modulo 2^CNT_W.
- Latency with ready=1 every cycle:
  - BRANCH: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR/STORE: 4 cycles.
  - LOAD: 5 cycles.
- Wait timeout: wait_cnt clears on entering FETCH or MEM and increments each cycle ready=0 in those states. If the wait reaches MAX_WAIT cycles without ready, set bus_err, deassert requests, go to HALT. Ready arriving in the same cycle the count reaches MAX_WAIT wins (no error).
- HALT: all strobes 0, halted=1. Exits only via reset. illegal and bus_err are cleared only by reset.
- Reset asserted mid-instruction: immediate return to IDLE, no partial write strobes after assertion.

Test Plan:
- Reset low, then high with run=1; ADDI (0010011), ready always 1 -> states 1,2,3,5; ir_we in cycle 1; reg_we=pc_we=1, wb_sel=000 in cycle 4; instret=1.
- LOAD with dmem_ready held low 3 cycles, then high -> dmem_re held 4 MEM cycles; reg_we with wb_sel=001 one cycle later; 5+3=8 cycles total.
- BEQ with branch_taken=1 then BNE with branch_taken=0 -> pc_sel=01 then 00, each pc_we in EXEC, no reg_we; instret +2.
- JALR -> WB cycle has reg_we=1, wb_sel=010, pc_sel=10; ECALL (1110011) next -> halted=1, instret unchanged, no strobes thereafter.
- imem_ready held 0 for MAX_WAIT=15 cycles -> bus_err=1, HALT. Second run with ready on the 15th cycle -> no error. Opcode 0000000 -> illegal=1, HALT.
- run dropped during MEM of a STORE -> store completes, pc_we fires, state IDLE. Reset pulsed low during EXEC -> IDLE, instret=0 asynchronously.
